// File: rtl/adder_arbiter_if.sv
// Requester-side and adder-side signals of the shared-adder arbiter.
// slave = the arbiter; master = requesters plus adder environment.
interface adder_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 25
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_datain1;
  logic [NREQ*WIDTH-1:0] req_datain2;
  logic [NREQ-1:0]       req_ack;
  logic [WIDTH-1:0]      req_dataout;
  logic                  req_carryout;
  logic [1:0]            req_exc;
  logic                  adder_valid;
  logic [WIDTH-1:0]      adder_datain1;
  logic [WIDTH-1:0]      adder_datain2;
  logic [WIDTH-1:0]      adder_dataout;
  logic                  adder_carryout;
  logic [1:0]            adder_exc;
  logic                  adder_ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  modport slave (
    input  req_valid, req_datain1, req_datain2,
    input  adder_dataout, adder_carryout, adder_exc, adder_ack,
    output req_ack, req_dataout, req_carryout, req_exc,
    output adder_valid, adder_datain1, adder_datain2, grant, busy
  );

  modport master (
    output req_valid, req_datain1, req_datain2,
    output adder_dataout, adder_carryout, adder_exc, adder_ack,
    input  req_ack, req_dataout, req_carryout, req_exc,
    input  adder_valid, adder_datain1, adder_datain2, grant, busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin owner of one shared adder: grant 1 cycle after request, req_ack 1 cycle after adder_ack.
// A requester holding valid after its ack parks the arbiter in RELEASE; a silent adder is cut off by a watchdog.
module adder_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 25,
  parameter int TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RSTK,
  adder_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_last;
  logic [TW-1:0]    r_wdog;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_req_ack;
  logic             r_busy;
  logic             r_adder_valid;
  logic [WIDTH-1:0] r_adder_d1;
  logic [WIDTH-1:0] r_adder_d2;
  logic [WIDTH-1:0] r_req_dout;
  logic             r_req_carry;
  logic [1:0]       r_req_exc;

  logic             w_any;
  logic [IW-1:0]    w_win;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic             w_owner_vld;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  // First valid requester after the previous owner, wrapping; the previous owner is searched last.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!w_any && bus.req_valid[rr_idx(r_last, off)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_last, off);
      end
    end
  end

  assign w_op1       = bus.req_datain1[int'(w_win)*WIDTH +: WIDTH];
  assign w_op2       = bus.req_datain2[int'(w_win)*WIDTH +: WIDTH];
  assign w_owner_vld = bus.req_valid[r_last];

  always_ff @(posedge CLK) begin
    if (RSTK) begin
      r_state       <= S_IDLE;
      r_last        <= IW'(NREQ - 1);
      r_wdog        <= '0;
      r_grant       <= '0;
      r_req_ack     <= '0;
      r_busy        <= 1'b0;
      r_adder_valid <= 1'b0;
      r_adder_d1    <= '0;
      r_adder_d2    <= '0;
      r_req_dout    <= '0;
      r_req_carry   <= 1'b0;
      r_req_exc     <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ack <= '0;
          if (w_any) begin
            r_state       <= S_BUSY;
            r_busy        <= 1'b1;
            r_grant       <= NREQ'(1) << w_win;
            r_adder_valid <= 1'b1;
            r_adder_d1    <= w_op1;
            r_adder_d2    <= w_op2;
            r_last        <= w_win;
            r_wdog        <= '0;
          end
        end
        S_BUSY: begin
          if (bus.adder_ack) begin
            r_adder_valid <= 1'b0;
            r_req_dout    <= bus.adder_dataout;
            r_req_carry   <= bus.adder_carryout;
            r_req_exc     <= bus.adder_exc;
            if (w_owner_vld) begin
              r_req_ack <= r_grant;
              r_state   <= S_RELEASE;
            end else begin
              // Owner gave up: result is kept on the bus but never acknowledged.
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (r_wdog == TW'(TIMEOUT - 1)) begin
            r_adder_valid <= 1'b0;
            r_req_dout    <= '0;
            r_req_carry   <= 1'b0;
            r_req_exc     <= 2'b11;
            r_req_ack     <= r_grant;
            r_state       <= S_RELEASE;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
        end
        S_RELEASE: begin
          r_req_ack <= '0;
          if (!w_owner_vld) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ack       = r_req_ack;
  assign bus.req_dataout   = r_req_dout;
  assign bus.req_carryout  = r_req_carry;
  assign bus.req_exc       = r_req_exc;
  assign bus.adder_valid   = r_adder_valid;
  assign bus.adder_datain1 = r_adder_d1;
  assign bus.adder_datain2 = r_adder_d2;
  assign bus.grant         = r_grant;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: transaction-level reference checked every cycle, plus literal scenario checks.
module tb_adder_arbiter;
  localparam int NREQ    = 2;
  localparam int WIDTH   = 25;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rstk;
  int   total = 0;
  int   bad   = 0;

  adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (clk),
    .RSTK (rstk),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: no DUT event within cycle budget at %0t", name, $time);
  endfunction

  // Adder stub: acks stub_lat cycles after adder_valid rises (0 = never); man_req bumps force one stray ack.
  int         stub_lat = 1;
  logic [1:0] stub_exc = 2'b00;
  int         man_req  = 0;
  int         man_seen = 0;
  int         stub_cnt = 0;
  always @(posedge clk) begin : stub
    logic [WIDTH:0] sum;
    #1;
    if (man_req != man_seen) begin
      man_seen           = man_req;
      bus.adder_ack      = 1'b1;
      bus.adder_dataout  = 25'h0000155;
      bus.adder_carryout = 1'b1;
      bus.adder_exc      = 2'b10;
    end else if (bus.adder_valid && stub_lat > 0) begin
      stub_cnt++;
      if (stub_cnt == stub_lat) begin
        sum = {1'b0, bus.adder_datain1} + {1'b0, bus.adder_datain2};
        bus.adder_ack      = 1'b1;
        bus.adder_dataout  = sum[WIDTH-1:0];
        bus.adder_carryout = sum[WIDTH];
        bus.adder_exc      = stub_exc;
      end else begin
        bus.adder_ack = 1'b0;
      end
    end else begin
      stub_cnt      = 0;
      bus.adder_ack = 1'b0;
    end
  end

  // Reference: owner index (-1 = free), cycles since grant, and whether the owner has been answered.
  int               m_owner = -1;
  int               m_last  = NREQ - 1;
  int               m_age   = 0;
  bit               m_done  = 1'b0;
  bit               m_live  = 1'b0;
  logic [NREQ-1:0]  e_grant, e_ack;
  logic             e_busy, e_av, e_carry;
  logic [WIDTH-1:0] e_d1, e_d2, e_dout;
  logic [1:0]       e_exc;

  always @(posedge clk) begin : mdl
    int pick;
    m_live <= 1'b1;
    if (rstk) begin
      m_owner <= -1; m_last <= NREQ - 1; m_age <= 0; m_done <= 1'b0;
      e_grant <= '0; e_ack <= '0; e_busy <= 1'b0; e_av <= 1'b0; e_carry <= 1'b0;
      e_d1 <= '0; e_d2 <= '0; e_dout <= '0; e_exc <= 2'b00;
    end else if (m_owner < 0) begin
      e_ack <= '0;
      pick = -1;
      for (int off = 1; off <= NREQ; off++)
        if (pick < 0 && bus.req_valid[(m_last + off) % NREQ]) pick = (m_last + off) % NREQ;
      if (pick >= 0) begin
        m_owner <= pick; m_last <= pick; m_age <= 1; m_done <= 1'b0;
        e_grant <= NREQ'(1 << pick); e_busy <= 1'b1; e_av <= 1'b1;
        e_d1 <= bus.req_datain1[pick*WIDTH +: WIDTH];
        e_d2 <= bus.req_datain2[pick*WIDTH +: WIDTH];
      end
    end else if (!m_done) begin
      if (bus.adder_ack) begin
        e_av <= 1'b0;
        e_dout <= bus.adder_dataout; e_carry <= bus.adder_carryout; e_exc <= bus.adder_exc;
        if (bus.req_valid[m_owner]) begin
          e_ack <= NREQ'(1 << m_owner); m_done <= 1'b1;
        end else begin
          m_owner <= -1; e_grant <= '0; e_busy <= 1'b0;
        end
      end else if (m_age == TIMEOUT) begin
        e_av <= 1'b0; e_dout <= '0; e_carry <= 1'b0; e_exc <= 2'b11;
        e_ack <= NREQ'(1 << m_owner); m_done <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      e_ack <= '0;
      if (!bus.req_valid[m_owner]) begin
        m_owner <= -1; m_done <= 1'b0; e_grant <= '0; e_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("grant",     32'(bus.grant),         32'(e_grant));
      chk("busy",      32'(bus.busy),          32'(e_busy));
      chk("req_ack",   32'(bus.req_ack),       32'(e_ack));
      chk("adder_vld", 32'(bus.adder_valid),   32'(e_av));
      chk("adder_d1",  32'(bus.adder_datain1), 32'(e_d1));
      chk("adder_d2",  32'(bus.adder_datain2), 32'(e_d2));
      chk("dataout",   32'(bus.req_dataout),   32'(e_dout));
      chk("carryout",  32'(bus.req_carryout),  32'(e_carry));
      chk("exc",       32'(bus.req_exc),       32'(e_exc));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_datain1[i*WIDTH +: WIDTH] = a;
    bus.req_datain2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_ack(input string name, input int bound, output int n);
    n = 0;
    while (bus.req_ack == '0 && n < bound) begin
      step();
      n++;
    end
    if (bus.req_ack == '0) fail_bound(name);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (bus.busy && n < bound) begin
      step();
      n++;
    end
    if (bus.busy) fail_bound(name);
  endtask

  initial begin
    int n;
    int errs;
    int acks;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] gq[$];

    rstk = 1'b1;
    bus.req_valid   = '0;
    bus.req_datain1 = '0;
    bus.req_datain2 = '0;
    step(); step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_av",    32'(bus.adder_valid), 0);
    rstk = 1'b0;
    step();

    // Single request, adder answers on the second valid cycle.
    stub_lat = 2;
    set_ops(0, 25'h0000005, 25'h0000003);
    set_ops(1, 25'h0000AAA, 25'h0000BBB);
    bus.req_valid = 2'b01;
    step();
    chk("single_av",    32'(bus.adder_valid), 1);
    chk("single_grant", 32'(bus.grant), 32'h1);
    set_ops(0, 25'h0000007, 25'h0000007);
    wait_ack("single_ack", 10, n);
    chk("single_lat",  32'(n), 2);
    chk("single_ack",  32'(bus.req_ack), 32'h1);
    chk("single_dout", 32'(bus.req_dataout), 32'h8);
    chk("single_exc",  32'(bus.req_exc), 0);
    chk("single_av0",  32'(bus.adder_valid), 0);
    step();
    chk("single_pulse", 32'(bus.req_ack), 0);
    bus.req_valid = 2'b00;
    wait_idle("single_idle", 10);

    // Contention from reset: each requester re-requests one cycle after its ack.
    rstk = 1'b1;
    step();
    rstk = 1'b0;
    stub_lat = 1;
    set_ops(0, 25'h0000010, 25'h0000001);
    set_ops(1, 25'h0000020, 25'h0000002);
    bus.req_valid = 2'b11;
    prev = '0;
    errs = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.grant != '0 && prev == '0) gq.push_back(bus.grant);
      if (bus.grant != '0 && !bus.busy) errs++;
      prev = bus.grant;
      for (int i = 0; i < NREQ; i++) bus.req_valid[i] = !bus.req_ack[i];
    end
    bus.req_valid = 2'b00;
    wait_idle("cont_idle", 20);
    chk("cont_count", 32'(gq.size() >= 4), 1);
    if (gq.size() >= 4) begin
      chk("cont_g0", 32'(gq[0]), 32'h1);
      chk("cont_g1", 32'(gq[1]), 32'h2);
      chk("cont_g2", 32'(gq[2]), 32'h1);
      chk("cont_g3", 32'(gq[3]), 32'h2);
    end
    chk("cont_busy", 32'(errs), 0);

    // Timeout: adder stays silent.
    stub_lat = 0;
    set_ops(1, 25'h0000123, 25'h0000456);
    bus.req_valid = 2'b10;
    step();
    chk("to_av", 32'(bus.adder_valid), 1);
    wait_ack("to_ack", 200, n);
    chk("to_lat",  32'(n), TIMEOUT);
    chk("to_ack",  32'(bus.req_ack), 32'h2);
    chk("to_exc",  32'(bus.req_exc), 32'h3);
    chk("to_dout", 32'(bus.req_dataout), 0);
    chk("to_av0",  32'(bus.adder_valid), 0);
    bus.req_valid = 2'b00;
    wait_idle("to_idle", 10);

    // Abort: requester 1 withdraws 2 cycles into BUSY, adder answers on its 6th valid cycle.
    stub_lat = 6;
    set_ops(1, 25'h1FFFFFE, 25'h0000001);
    bus.req_valid = 2'b10;
    n = 0; acks = 0; errs = 0;
    step(); n++;
    step(); n++;
    bus.req_valid = 2'b00;
    while (bus.busy && n < 20) begin
      if (!bus.adder_valid) errs++;
      step(); n++;
      if (bus.req_ack != '0) acks++;
    end
    if (bus.busy) fail_bound("abort_idle");
    chk("abort_lat",  32'(n), 7);
    chk("abort_acks", 32'(acks), 0);
    chk("abort_av",   32'(errs), 0);
    chk("abort_dout", 32'(bus.req_dataout), 32'h1FFFFFF);

    // Stale valid with carry and exception passthrough.
    stub_lat = 1;
    stub_exc = 2'b01;
    set_ops(0, 25'h1FFFFFF, 25'h0000001);
    bus.req_valid = 2'b01;
    step();
    wait_ack("stale_ack", 10, n);
    chk("stale_carry", 32'(bus.req_carryout), 1);
    chk("stale_exc",   32'(bus.req_exc), 32'h1);
    chk("stale_dout",  32'(bus.req_dataout), 0);
    stub_exc = 2'b00;
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.adder_valid || !bus.busy || bus.grant != 2'b01) errs++;
    end
    chk("stale_hold", 32'(errs), 0);
    bus.req_valid = 2'b00;
    step();
    chk("stale_rel", 32'(bus.busy), 0);
    bus.req_valid = 2'b01;
    step();
    chk("stale_regrant", 32'(bus.grant), 32'h1);
    chk("stale_av",      32'(bus.adder_valid), 1);
    wait_ack("stale_ack2", 10, n);
    bus.req_valid = 2'b00;
    wait_idle("stale_idle", 10);

    // Reset in the middle of BUSY, then a stray ack from the adder.
    stub_lat = 0;
    bus.req_valid = 2'b10;
    step(); step(); step();
    rstk = 1'b1;
    bus.req_valid = 2'b00;
    step();
    chk("mid_grant", 32'(bus.grant), 0);
    chk("mid_busy",  32'(bus.busy), 0);
    chk("mid_av",    32'(bus.adder_valid), 0);
    chk("mid_d1",    32'(bus.adder_datain1), 0);
    rstk = 1'b0;
    man_req++;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.req_ack != '0 || bus.busy) acks++;
    end
    chk("mid_late_ack", 32'(acks), 0);
    stub_lat = 1;
    bus.req_valid = 2'b11;
    step();
    chk("mid_first_grant", 32'(bus.grant), 32'h1);
    bus.req_valid = 2'b00;
    wait_idle("mid_idle", 10);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares the single 25-bit integer adder of the FPU datapath between NREQ requesters, such as the Booth multiplier and the add/align unit. Each requester uses the same valid/ack handshake it would use with a private adder. The arbiter serialises transactions, holds operands stable for the adder, and returns result, carry and exception to the granted requester only. A watchdog terminates transactions the adder never acknowledges.

## Interface
Parameters:
- NREQ, 2, number of requesters (legal 2..4)
- WIDTH, 25, operand/result width
- TIMEOUT, 64, max cycles in BUSY before forced completion (>=2)

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTK  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NREQ  per-requester request, held until ack
- req_datain1  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_datain2  in  NREQ*WIDTH  operand B, same packing
- req_ack  out  NREQ  one-hot, single-cycle completion pulse
- req_dataout  out  WIDTH  result, valid only while req_ack is nonzero
- req_carryout  out  1  adder carry, qualified by req_ack
- req_exc  out  2  adder exception, qualified by req_ack; 2'b11 = timeout
- adder_valid  out  1  request to shared adder
- adder_datain1  out  WIDTH  latched operand A
- adder_datain2  out  WIDTH  latched operand B
- adder_dataout  in  WIDTH  adder result
- adder_carryout  in  1  adder carry
- adder_exc  in  2  adder exception
- adder_ack  in  1  adder completion, single-cycle pulse
- grant  out  NREQ  one-hot owner of the adder, 0 in IDLE
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, BUSY, RELEASE. All outputs are registered.
- Round-robin pointer `last`: reset value NREQ-1. Search order is last+1, last+2, … modulo NREQ.
- IDLE:
  - If any req_valid is high, pick the winner g by search order.
  - Register: grant = 1<<g, adder_datain1/2 = operands of g, adder_valid = 1, last = g, watchdog = 0.
  - Go to BUSY.
- BUSY:
  - adder_valid and operands are held constant. The watchdog increments each cycle.
  - If adder_ack: capture adder_dataout, adder_carryout and adder_exc into req_dataout, req_carryout and req_exc; clear adder_valid.
    - If req_valid[g] is still high: pulse req_ack[g] and go to RELEASE.
    - If req_valid[g] has dropped (abort): no req_ack; clear grant; go to IDLE.
  - Else, if the watchdog reaches TIMEOUT-1: clear adder_valid; drive req_dataout = 0, req_carryout = 0, req_exc = 2'b11; pulse req_ack[g]; go to RELEASE.
- RELEASE:
  - req_ack = 0.
  - Stay while req_valid[g] is high, so a stale valid never retriggers a transaction.
  - When req_valid[g] is low: clear grant, go to IDLE.
- Operands of non-granted requesters are ignored. Changes to the granted requester's operands after the grant are ignored.
- adder_ack while adder_valid is low is ignored.
- req_dataout, req_carryout and req_exc hold their last captured value between transactions.
- Reset, including reset mid-BUSY: state = IDLE, last = NREQ-1, watchdog = 0. All outputs are 0: grant, busy, req_ack, req_dataout, req_carryout, req_exc, adder_valid, adder_datain1, adder_datain2. An in-flight adder_ack arriving after reset is ignored.

## Timing
- Request seen high in IDLE at cycle 0 → grant, busy and adder_valid high at cycle 1.
- adder_ack sampled at cycle k (k>=1) → req_ack[g] high with result at cycle k+1, for exactly one cycle. adder_valid is low at k+1.
- Requester drops req_valid at k+2 → RELEASE sees it low at k+2 → IDLE at k+3. The next grant is issued at k+4 at the earliest.
- Back-to-back throughput: one transaction per (adder latency + 3) cycles.
- Timeout: adder_valid rises at cycle 1 → req_ack with exc 2'b11 at cycle TIMEOUT+1.
- Simultaneous requests: exactly one grant per IDLE cycle; grant is never multi-hot.

## Test plan
- Single request: req 0 with A=25'h0000005, B=25'h0000003; adder acks 2 cycles after adder_valid with dataout 8 → adder_valid rises at cycle 1; req_ack = 2'b01 for one cycle with req_dataout = 25'h0000008, req_exc = 0.
- Contention: req 0 and req 1 both held continuously from reset, adder acks 1 cycle after valid → grants alternate 0,1,0,1; no grant while busy; grant always one-hot.
- Timeout: TIMEOUT=64, adder never acks → req_ack[g] at cycle 65 with req_dataout = 0, req_exc = 2'b11; adder_valid low from that cycle.
- Abort: req 1 drops valid 2 cycles into BUSY, adder acks later with dataout 25'h1FFFFFF → no req_ack; adder_valid held until the ack; IDLE the cycle after the ack.
- Stale valid: requester holds valid 4 cycles after req_ack → state stays RELEASE; no second adder_valid until valid falls; then a normal IDLE re-grant.
- Reset mid-BUSY: assert RSTK during BUSY → next cycle all outputs 0 and state IDLE; a late adder_ack produces no req_ack; the first grant after reset goes to req 0.
